// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the instruction-memory request/response port, the
// decode-side instruction handshake and the redirect input of fetch_ctrl.
//   master : fetch controller side (drives requests and the instruction buffer)
//   slave  : environment side (memory, decode and execute)
interface fetch_ctrl_if;
    // Instruction-memory request / response
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    // Instruction buffer towards decode
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    // Branch/jump redirect from execute
    logic        redirect;
    logic [31:0] redirect_target;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready,
        input  redirect, redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready,
        output redirect, redirect_target
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller. Owns the PC, issues one memory
// request at a time, buffers one returned instruction for decode and handles
// branch/jump redirects, including discarding a fetch already in flight.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : fetch_ctrl_if.master (imem request/response, decode handshake,
//            redirect and redirect_target)
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic [31:0] target_aligned;
    logic        unused_target_lsb;

    assign target_aligned    = {bus.redirect_target[31:2], 2'b00};
    assign unused_target_lsb = ^bus.redirect_target[1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;

        unique case (state_q)
            StReq: begin
                if (bus.imem_req_ready) begin
                    state_d = StWait;
                    // Request accepted in the same cycle as a redirect is stale.
                    kill_d  = bus.redirect;
                end
            end
            StWait: begin
                if (bus.imem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (kill_q || bus.redirect) begin
                        state_d = StReq;
                    end else begin
                        state_d     = StHold;
                        inst_data_d = bus.imem_rsp_data;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + 32'd4;
                    end
                end else if (bus.redirect) begin
                    kill_d = 1'b1;
                end
            end
            StHold: begin
                // A redirect drops the buffered instruction; otherwise wait
                // for decode to take it.
                if (bus.redirect || bus.inst_ready) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase

        // Redirect overrides any PC update, whatever the state.
        if (bus.redirect) begin
            pc_d = target_aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StReq;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            inst_data_q <= 32'h0;
            inst_pc_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    // Valids are masked while reset is held so nothing is offered during reset.
    assign bus.imem_req_valid = (state_q == StReq) && !reset;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (state_q == StHold) && !reset;
    assign bus.inst_data      = inst_data_q;
    assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A directed table of
// per-cycle vectors, a hand sequence on a second instance with RESET_PC at the
// top of the address space, and a randomized run against a queue-based model.
module tb_fetch_ctrl;

    logic clk;
    logic reset_a;
    logic reset_b;

    fetch_ctrl_if ifa ();
    fetch_ctrl_if ifb ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ifa)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        irdy;
        logic        redir;
        logic [31:0] tgt;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_data;
    } vec_t;

    vec_t tab[$];

    localparam logic [31:0] D = 32'hD000_0000;

    // Reference model: fetch stream as a queue of outstanding requests plus a
    // one-entry buffer.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    req_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_bv;
    logic [31:0] m_bd;
    logic [31:0] m_bp;

    bit          mem_busy;
    int          mem_cnt;

    logic        r_rst, r_rdy, r_rspv, r_irdy, r_redir, e_rv;
    logic [31:0] r_rspd, r_tgt;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic rdy, input logic rspv,
                       input logic [31:0] rspd, input logic irdy, input logic redir,
                       input logic [31:0] tgt, input logic e_rv, input logic [31:0] e_addr,
                       input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_data);
        vec_t v;
        v = '{rst, rdy, rspv, rspd, irdy, redir, tgt, e_rv, e_addr, e_iv, e_ipc, e_data};
        tab.push_back(v);
    endtask

    task automatic drive_a(input logic rst, input logic rdy, input logic rspv,
                           input logic [31:0] rspd, input logic irdy, input logic redir,
                           input logic [31:0] tgt);
        reset_a             = rst;
        ifa.imem_req_ready  = rdy;
        ifa.imem_rsp_valid  = rspv;
        ifa.imem_rsp_data   = rspd;
        ifa.inst_ready      = irdy;
        ifa.redirect        = redir;
        ifa.redirect_target = tgt;
    endtask

    task automatic chk_a(input string pfx, input int idx, input logic rv,
                         input logic [31:0] addr, input logic iv, input logic [31:0] ipc,
                         input logic [31:0] data);
        chk({pfx, "_req_valid"}, idx, {31'h0, ifa.imem_req_valid}, {31'h0, rv});
        chk({pfx, "_req_addr"}, idx, ifa.imem_req_addr, addr);
        chk({pfx, "_inst_valid"}, idx, {31'h0, ifa.inst_valid}, {31'h0, iv});
        chk({pfx, "_inst_pc"}, idx, ifa.inst_pc, ipc);
        chk({pfx, "_inst_data"}, idx, ifa.inst_data, data);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc = 32'h0;
        m_bv = 1'b0;
        m_bd = 32'h0;
        m_bp = 32'h0;
    endtask

    task automatic model_step(input logic rst, input logic rdy, input logic rspv,
                              input logic [31:0] rspd, input logic irdy, input logic redir,
                              input logic [31:0] tgt);
        bit          pre_bv;
        bit          pre_req;
        logic [31:0] pre_pc;
        req_t        e;
        if (rst) begin
            model_reset();
            return;
        end
        pre_bv  = m_bv;
        pre_pc  = m_pc;
        pre_req = !m_bv && (m_q.size() == 0);
        if (rspv && m_q.size() > 0) begin
            e = m_q.pop_front();
            if (!e.stale && !redir) begin
                m_bv = 1'b1;
                m_bd = rspd;
                m_bp = e.addr;
                m_pc = e.addr + 32'd4;
            end
        end
        if (pre_bv && irdy && !redir) m_bv = 1'b0;
        if (pre_req && rdy) begin
            e.addr  = pre_pc;
            e.stale = redir;
            m_q.push_back(e);
        end
        if (redir) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_bv = 1'b0;
            foreach (m_q[j]) m_q[j].stale = 1'b1;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive_a(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset_b             = 1'b1;
        ifb.imem_req_ready  = 1'b0;
        ifb.imem_rsp_valid  = 1'b0;
        ifb.imem_rsp_data   = 32'h0;
        ifb.inst_ready      = 1'b0;
        ifb.redirect        = 1'b0;
        ifb.redirect_target = 32'h0;

        // rst rdy rspv rspd  irdy redir tgt | rv addr iv ipc data
        row(1, 0, 0, 32'h0,      0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
        row(0, 1, 0, 32'h0,      1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0);
        row(0, 0, 1, D | 32'h0,  1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
        row(0, 1, 0, 32'h0,      1, 0, 32'h0,   0, 32'h4,   1, 32'h0,   D);
        row(0, 1, 0, 32'h0,      1, 0, 32'h0,   1, 32'h4,   0, 32'h0,   D);
        row(0, 0, 1, D | 32'h4,  1, 0, 32'h0,   0, 32'h4,   0, 32'h0,   D);
        for (int i = 0; i < 5; i++)
            row(0, 0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h8,   1, 32'h4,   D | 32'h4);
        row(0, 0, 0, 32'h0,      1, 0, 32'h0,   0, 32'h8,   1, 32'h4,   D | 32'h4);
        row(0, 1, 0, 32'h0,      0, 0, 32'h0,   1, 32'h8,   0, 32'h4,   D | 32'h4);
        // Redirect to 0x100 in WAIT, stale response four cycles after accept
        row(0, 0, 0, 32'h0,      0, 1, 32'h100, 0, 32'h8,   0, 32'h4,   D | 32'h4);
        row(0, 0, 0, 32'h0,      0, 0, 32'h0,   0, 32'h100, 0, 32'h4,   D | 32'h4);
        row(0, 0, 0, 32'h0,      0, 0, 32'h0,   0, 32'h100, 0, 32'h4,   D | 32'h4);
        row(0, 0, 1, D | 32'h8,  1, 0, 32'h0,   0, 32'h100, 0, 32'h4,   D | 32'h4);
        row(0, 1, 0, 32'h0,      1, 0, 32'h0,   1, 32'h100, 0, 32'h4,   D | 32'h4);
        row(0, 0, 1, D | 32'h100, 0, 0, 32'h0,  0, 32'h100, 0, 32'h4,   D | 32'h4);
        // Redirect to 0x203 in HOLD with inst_ready high
        row(0, 0, 0, 32'h0,      1, 1, 32'h203, 0, 32'h104, 1, 32'h100, D | 32'h100);
        row(0, 0, 0, 32'h0,      0, 0, 32'h0,   1, 32'h200, 0, 32'h100, D | 32'h100);
        row(0, 1, 0, 32'h0,      0, 0, 32'h0,   1, 32'h200, 0, 32'h100, D | 32'h100);
        // Two redirects during one WAIT
        row(0, 0, 0, 32'h0,      0, 1, 32'h40,  0, 32'h200, 0, 32'h100, D | 32'h100);
        row(0, 0, 0, 32'h0,      0, 1, 32'h80,  0, 32'h40,  0, 32'h100, D | 32'h100);
        row(0, 0, 1, D | 32'h200, 0, 0, 32'h0,  0, 32'h80,  0, 32'h100, D | 32'h100);
        row(0, 1, 0, 32'h0,      0, 0, 32'h0,   1, 32'h80,  0, 32'h100, D | 32'h100);
        row(0, 0, 1, D | 32'h80, 0, 0, 32'h0,   0, 32'h80,  0, 32'h100, D | 32'h100);
        row(0, 0, 0, 32'h0,      1, 0, 32'h0,   0, 32'h84,  1, 32'h80,  D | 32'h80);
        // Redirect in REQ accepted same cycle, then in REQ not accepted
        row(0, 1, 0, 32'h0,      0, 1, 32'h10,  1, 32'h84,  0, 32'h80,  D | 32'h80);
        row(0, 0, 1, D | 32'h84, 0, 0, 32'h0,   0, 32'h10,  0, 32'h80,  D | 32'h80);
        row(0, 0, 0, 32'h0,      0, 1, 32'h20,  1, 32'h10,  0, 32'h80,  D | 32'h80);
        row(0, 1, 0, 32'h0,      0, 0, 32'h0,   1, 32'h20,  0, 32'h80,  D | 32'h80);
        // Redirect in WAIT coinciding with the response
        row(0, 0, 1, D | 32'h20, 0, 1, 32'h30,  0, 32'h20,  0, 32'h80,  D | 32'h80);
        row(0, 0, 0, 32'h0,      0, 0, 32'h0,   1, 32'h30,  0, 32'h80,  D | 32'h80);

        @(posedge clk); #1;
        foreach (tab[i]) begin
            drive_a(tab[i].rst, tab[i].rdy, tab[i].rspv, tab[i].rspd, tab[i].irdy,
                    tab[i].redir, tab[i].tgt);
            #1;
            chk_a("tab", i, tab[i].e_rv, tab[i].e_addr, tab[i].e_iv, tab[i].e_ipc,
                  tab[i].e_data);
            @(posedge clk); #1;
        end

        // Second instance: fetch at the top of the address space and wrap.
        chk("b_rst_req_valid", 0, {31'h0, ifb.imem_req_valid}, 32'h0);
        chk("b_rst_req_addr", 0, ifb.imem_req_addr, 32'hFFFF_FFFC);
        chk("b_rst_inst_valid", 0, {31'h0, ifb.inst_valid}, 32'h0);
        reset_b = 1'b0;
        ifb.imem_req_ready = 1'b1;
        #1;
        chk("b_first_req_valid", 0, {31'h0, ifb.imem_req_valid}, 32'h1);
        chk("b_first_req_addr", 0, ifb.imem_req_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        ifb.imem_req_ready = 1'b0;
        ifb.imem_rsp_valid = 1'b1;
        ifb.imem_rsp_data  = 32'h1234_5678;
        @(posedge clk); #1;
        ifb.imem_rsp_valid = 1'b0;
        chk("b_hold_inst_valid", 0, {31'h0, ifb.inst_valid}, 32'h1);
        chk("b_hold_inst_pc", 0, ifb.inst_pc, 32'hFFFF_FFFC);
        chk("b_hold_inst_data", 0, ifb.inst_data, 32'h1234_5678);
        chk("b_hold_req_addr", 0, ifb.imem_req_addr, 32'h0);
        ifb.inst_ready = 1'b1;
        @(posedge clk); #1;
        ifb.inst_ready = 1'b0;
        chk("b_wrap_req_valid", 0, {31'h0, ifb.imem_req_valid}, 32'h1);
        chk("b_wrap_req_addr", 0, ifb.imem_req_addr, 32'h0);
        ifb.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        ifb.imem_req_ready = 1'b0;
        chk("b_wait_req_valid", 0, {31'h0, ifb.imem_req_valid}, 32'h0);
        reset_b = 1'b1;
        @(posedge clk); #1;
        chk("b_rst2_req_valid", 0, {31'h0, ifb.imem_req_valid}, 32'h0);
        chk("b_rst2_req_addr", 0, ifb.imem_req_addr, 32'hFFFF_FFFC);
        chk("b_rst2_inst_valid", 0, {31'h0, ifb.inst_valid}, 32'h0);
        chk("b_rst2_inst_pc", 0, ifb.inst_pc, 32'h0);
        chk("b_rst2_inst_data", 0, ifb.inst_data, 32'h0);
        reset_b = 1'b0;
        #1;
        chk("b_rel_req_valid", 0, {31'h0, ifb.imem_req_valid}, 32'h1);
        chk("b_rel_req_addr", 0, ifb.imem_req_addr, 32'hFFFF_FFFC);

        // Randomized run on the first instance against the model.
        drive_a(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        model_reset();
        mem_busy = 1'b0;
        mem_cnt  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_rst  = ($urandom_range(0, 199) == 0);
            r_rspv = 1'b0;
            r_rspd = $urandom;
            if (r_rst) begin
                mem_busy = 1'b0;
            end else if (mem_busy) begin
                if (mem_cnt == 0) begin
                    r_rspv   = 1'b1;
                    mem_busy = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            r_rdy   = ($urandom_range(0, 2) != 0);
            r_irdy  = ($urandom_range(0, 3) != 0);
            r_redir = !r_rst && ($urandom_range(0, 11) == 0);
            r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                  : $urandom;
            drive_a(r_rst, r_rdy, r_rspv, r_rspd, r_irdy, r_redir, r_tgt);
            #1;
            e_rv = !r_rst && !m_bv && (m_q.size() == 0);
            chk_a("rnd", cyc, e_rv, m_pc, !r_rst && m_bv, m_bp, m_bd);
            if (!r_rst && ifa.imem_req_valid && r_rdy) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(0, 3);
            end
            model_step(r_rst, r_rdy, r_rspv, r_rspd, r_irdy, r_redir, r_tgt);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
